// File: rtl/bz_link_flit_assembler.sv
// Link-side flit assembler: packs header + 3 data flits into one route/payload
// word behind a single output register, and counts packets whose last flit is flagged.
module bz_link_flit_assembler #(
  parameter int unsigned FLIT_W    = 11,
  parameter int unsigned ROUTE_W   = 10,
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned ERR_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FLIT_W-1:0]    flit_in,
  input  logic                 flit_valid,
  output logic                 flit_ready,
  output logic [ROUTE_W-1:0]   pkt_route,
  output logic [PAYLOAD_W-1:0] pkt_payload,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [ERR_W-1:0]     err_count,
  output logic                 busy
);

  localparam int unsigned TAIL_W = PAYLOAD_W - 2 * FLIT_W;

  typedef enum logic [1:0] {HEAD, D0, D1, D2} state_t;

  state_t             state;
  state_t             state_next;
  logic [ROUTE_W-1:0] route_q;
  logic [FLIT_W-1:0]  d0_q;
  logic [FLIT_W-1:0]  d1_q;
  logic               flit_xfer;
  logic               pkt_xfer;

  // Final flit only lands when the output slot is empty or draining this cycle.
  assign flit_ready = !reset && ((state != D2) || !pkt_valid || pkt_ready);
  assign flit_xfer  = flit_valid && flit_ready;
  assign pkt_xfer   = pkt_valid && pkt_ready;
  assign busy       = (state != HEAD);

  // Next-state logic: advance only on an accepted flit.
  always_comb begin
    state_next = state;
    if (flit_xfer) begin
      case (state)
        HEAD:    state_next = D0;
        D0:      state_next = D1;
        D1:      state_next = D2;
        default: state_next = HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HEAD;
    end else begin
      state <= state_next;
    end
  end

  // Datapath capture, output register and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      route_q     <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      pkt_route   <= '0;
      pkt_payload <= '0;
      pkt_valid   <= 1'b0;
      err_count   <= '0;
    end else begin
      if (flit_xfer && state == D2) begin
        pkt_route   <= route_q;
        pkt_payload <= {flit_in[TAIL_W-1:0], d1_q, d0_q};
        pkt_valid   <= 1'b1;
        if (flit_in[FLIT_W-1] && (err_count != {ERR_W{1'b1}})) begin
          err_count <= err_count + ERR_W'(1);
        end
      end else if (pkt_xfer) begin
        pkt_valid <= 1'b0;
      end
      if (flit_xfer) begin
        case (state)
          HEAD:    route_q <= flit_in[ROUTE_W-1:0];
          D0:      d0_q    <= flit_in;
          D1:      d1_q    <= flit_in;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bz_link_flit_assembler.md
Name: bz_link_flit_assembler

Overview:
- Upstream stage of the host core's board-to-board input path.
- Consumes 11-bit flits from the inter-board link (top_in / valid / ready) and packs each 4-flit sequence (1 header, 3 data) into one route + payload word.
- The host core's upstream routing logic consumes that word over a valid/ready handshake.
- Also counts malformed packets.

Parameters:
- FLIT_W, 11, width of one link flit.
- ROUTE_W, 10, route field width taken from header flit bits [9:0].
- PAYLOAD_W, 32, assembled payload width.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flit_in  input  FLIT_W  incoming link flit.
- flit_valid  input  1  flit_in is valid this cycle.
- flit_ready  output  1  block accepts flit_in this cycle.
- pkt_route  output  ROUTE_W  route of the assembled packet.
- pkt_payload  output  PAYLOAD_W  assembled payload.
- pkt_valid  output  1  pkt_route/pkt_payload are valid.
- pkt_ready  input  1  downstream accepts the packet.
- err_count  output  ERR_W  number of packets with a nonzero final-flit bit 10; saturates.
- busy  output  1  high when the FSM is not in HEAD.

Behaviour:
- Transfer rules:
  - A flit transfers on a cycle with flit_valid & flit_ready.
  - A packet transfers on a cycle with pkt_valid & pkt_ready.
- FSM states and transitions (each transition happens on a flit transfer):
  - HEAD: capture route = flit_in[9:0]; ignore flit_in[10]; go to D0.
  - D0: payload[10:0] = flit_in; go to D1.
  - D1: payload[21:11] = flit_in; go to D2.
  - D2: payload[31:22] = flit_in[9:0]; load the output register; pkt_valid <= 1; go to HEAD.
- Error counting in D2: if flit_in[10] = 1, err_count increments by 1 (saturating at all-ones) and the packet is still emitted.
- Output buffering: one output register.
  - In HEAD, D0 and D1, flit_ready = 1 whenever not in reset, so assembly overlaps with a stalled output.
  - In D2, flit_ready = !pkt_valid | pkt_ready. The final flit is accepted only if the output slot is empty or drains in the same cycle.
- Simultaneous D2 accept and output drain in one cycle: the new packet replaces the old one, pkt_valid stays 1, and nothing is lost or duplicated.
- pkt_valid clears on a packet transfer with no D2 accept in the same cycle.
- pkt_route and pkt_payload hold stable while pkt_valid = 1 and pkt_ready = 0.
- Latency: pkt_valid rises on the cycle after the D2 flit transfer.
- Peak throughput: 1 packet per 4 cycles.
- Reset values:
  - state = HEAD; pkt_valid = 0; pkt_route = 0; pkt_payload = 0; err_count = 0; busy = 0.
  - flit_ready = 0 while reset is high.
- Reset mid-packet: the partial packet is discarded and the next flit after reset is treated as a header. Reset also drops a pending pkt_valid.
- flit_in is ignored whenever flit_valid = 0.
- The FSM never advances without a flit transfer.

Test Plan:
- Basic packet: with pkt_ready = 1, send flits 11'b01000100000, 11'd1, 11'd7, 11'd31 back-to-back → one cycle after the 4th flit: pkt_valid = 1, pkt_route = 10'h220, pkt_payload = 32'h07C03801, err_count = 0.
- Output backpressure: pkt_ready = 0, send packet A then packet B.
  - Required: flit_ready stays 1 through B's header, D0 and D1, then drops to 0 in D2.
  - pkt_payload holds A's value.
  - Raising pkt_ready for 1 cycle transfers A and accepts B's final flit in the same cycle; B appears the next cycle.
- Error flag: final flit 11'h400 with data flits 0, 0 → payload = 32'h00000000 and err_count = 1. With err_count preloaded by sending 65535 bad packets, one more keeps err_count = 16'hFFFF.
- Bubbles: flit_valid toggled 1/0 every cycle across one packet → identical route/payload to the basic packet case; busy stays high from the header until D2 is accepted.
- Mid-packet reset: header and D0 sent, reset pulsed for 1 cycle, then a full packet with route 10'h003 and data 5, 0, 0 → exactly one packet out, with route 10'h003 and payload 32'h00000005.
- Streaming: 8 back-to-back packets with pkt_ready = 1 → 8 pkt_valid pulses spaced 4 cycles apart, payloads in order, no flit_ready deassertion.
